config_stream_loader: RTL and testbench

- Configuration initiator for the tile array: consumes a 32-bit configuration word stream with a valid/ready handshake.
- Drives the shared config_addr/config_data bus that every tile's address matchers decode.
- Sequences framed write records (header, addr/data pairs, checksum trailer) into timed bus writes.
- Holds the bus at a reserved idle address whenever no write is active, so no tile's config enable asserts spuriously.

---
 rtl/config_stream_loader.sv | 154 +++++++++++++++
 tb/tb_config_stream_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_stream_loader.sv
// Configuration stream loader: turns framed header/addr/data/checksum word streams
// into timed writes on the shared tile configuration bus, idling at a reserved address.
module config_stream_loader #(
  parameter logic [15:0] MAGIC       = 16'hC0F1,
  parameter logic [31:0] IDLE_ADDR   = 32'hFFFF_FFFF,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] write_count
);

  typedef enum logic [2:0] {HDR, ADDR, DATA, WRITE, CHK} state_e;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] remaining_q, remaining_d;
  logic [31:0] addr_reg_q, addr_reg_d;
  logic [31:0] checksum_q, checksum_d;
  logic [3:0]  hold_q, hold_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_data_q, bus_data_d;
  logic        in_ready_q, in_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [15:0] write_count_q, write_count_d;
  logic        accept;

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    addr_reg_d    = addr_reg_q;
    checksum_d    = checksum_q;
    hold_d        = hold_q;
    bus_addr_d    = bus_addr_q;
    bus_data_d    = bus_data_q;
    busy_d        = busy_q;
    done_d        = done_q;
    error_d       = error_q;
    write_count_d = write_count_q;

    case (state_q)
      HDR: begin
        if (accept) begin
          if (in_data[31:16] == MAGIC) begin
            remaining_d   = in_data[15:0];
            write_count_d = 16'd0;
            done_d        = 1'b0;
            error_d       = 1'b0;
            busy_d        = 1'b1;
            checksum_d    = in_data;
            state_d       = (in_data[15:0] == 16'd0) ? CHK : ADDR;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ADDR: begin
        if (accept) begin
          addr_reg_d = in_data;
          checksum_d = checksum_q ^ in_data;
          state_d    = DATA;
        end
      end
      DATA: begin
        // The bus register doubles as the data register so the write appears one edge later.
        if (accept) begin
          checksum_d = checksum_q ^ in_data;
          bus_addr_d = addr_reg_q;
          bus_data_d = in_data;
          hold_d     = 4'd0;
          state_d    = WRITE;
        end
      end
      WRITE: begin
        if (hold_q == HOLD_LAST) begin
          write_count_d = (write_count_q == 16'hFFFF) ? write_count_q : write_count_q + 16'd1;
          remaining_d   = remaining_q - 16'd1;
          bus_addr_d    = IDLE_ADDR;
          bus_data_d    = 32'd0;
          state_d       = (remaining_q != 16'd1) ? ADDR : CHK;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      CHK: begin
        if (accept) begin
          done_d  = 1'b1;
          error_d = (in_data != checksum_q) ? 1'b1 : error_q;
          busy_d  = 1'b0;
          state_d = HDR;
        end
      end
      default: begin
        state_d    = HDR;
        bus_addr_d = IDLE_ADDR;
        bus_data_d = 32'd0;
      end
    endcase

    in_ready_d = (state_d != WRITE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= HDR;
      remaining_q   <= 16'd0;
      addr_reg_q    <= 32'd0;
      checksum_q    <= 32'd0;
      hold_q        <= 4'd0;
      bus_addr_q    <= IDLE_ADDR;
      bus_data_q    <= 32'd0;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      write_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      addr_reg_q    <= addr_reg_d;
      checksum_q    <= checksum_d;
      hold_q        <= hold_d;
      bus_addr_q    <= bus_addr_d;
      bus_data_q    <= bus_data_d;
      in_ready_q    <= in_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      write_count_q <= write_count_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign config_addr = bus_addr_q;
  assign config_data = bus_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign write_count = write_count_q;

endmodule

// File: tb/tb_config_stream_loader.sv
// Bench for config_stream_loader: frames are generated from a high-level model,
// expected bus writes and frame outcomes are queued and checked by a monitor.
module tb_config_stream_loader;

  localparam int          HOLD = 2;
  localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] config_addr, config_data;
  logic        busy, done, error;
  logic [15:0] write_count;

  int checks = 0;
  int errors = 0;

  logic [63:0] expWrites[$];
  logic [17:0] expResults[$];

  logic [31:0] frameAddr[8];
  logic [31:0] frameData[8];

  config_stream_loader #(
    .MAGIC(16'hC0F1), .IDLE_ADDR(IDLE), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .config_addr(config_addr), .config_data(config_data),
    .busy(busy), .done(done), .error(error), .write_count(write_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Offer one word after an optional gap; returns just after the accepting edge.
  task automatic sendWord(input logic [31:0] w, input int gap);
    int waitCycles;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_data  = w;
    in_valid = 1'b1;
    waitCycles = 0;
    while (!in_ready && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL handshakeTimeout actual=in_ready_low expected=in_ready_high");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Reference model: a frame's checksum is the XOR of header and every pair word;
  // each pair becomes one bus write in order; the outcome is done with error on mismatch.
  task automatic applyStimulus(input int n, input logic [31:0] trailer, input bit useGaps);
    logic [31:0] header;
    logic [31:0] sum;
    header = {16'hC0F1, 16'(n)};
    sum = header;
    for (int i = 0; i < n; i++) sum = sum ^ frameAddr[i] ^ frameData[i];
    sendWord(header, useGaps ? int'($urandom_range(0, 2)) : 0);
    checkOutput("hdrBusy", {31'd0, busy}, 32'd1);
    checkOutput("hdrDoneClear", {31'd0, done}, 32'd0);
    checkOutput("hdrErrorClear", {31'd0, error}, 32'd0);
    for (int i = 0; i < n; i++) begin
      sendWord(frameAddr[i], useGaps ? int'($urandom_range(0, 2)) : 0);
      expWrites.push_back({frameAddr[i], frameData[i]});
      sendWord(frameData[i], useGaps ? int'($urandom_range(0, 2)) : 0);
    end
    expResults.push_back({1'b1, (trailer != sum), 16'(n)});
    sendWord(trailer, useGaps ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic sendBadHeader(input logic [31:0] hdr);
    sendWord(hdr, 0);
    checkOutput("badMagicError", {31'd0, error}, 32'd1);
    checkOutput("badMagicBusy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("badMagicStayHdr", {31'd0, in_ready}, 32'd1);
  endtask

  // Monitor: matches each bus write and each frame completion against the queues.
  logic        prevBusy = 1'b0;
  bit          inWrite = 1'b0;
  int          holdLen = 0;
  logic [31:0] curAddr, curData;
  logic [63:0] expW;
  logic [17:0] expR;

  always @(negedge clk) begin
    if (!reset) begin
      inWrite  = 1'b0;
      prevBusy = 1'b0;
    end else begin
      if (config_addr != IDLE) begin
        if (!inWrite) begin
          inWrite = 1'b1;
          holdLen = 1;
          curAddr = config_addr;
          curData = config_data;
          if (expWrites.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedWrite actual=%h/%h expected=no_write", config_addr, config_data);
          end else begin
            expW = expWrites.pop_front();
            checkOutput("writeAddr", config_addr, expW[63:32]);
            checkOutput("writeData", config_data, expW[31:0]);
          end
        end else begin
          holdLen++;
          checkOutput("holdAddrStable", config_addr, curAddr);
          checkOutput("holdDataStable", config_data, curData);
        end
        checkOutput("readyLowInWrite", {31'd0, in_ready}, 32'd0);
      end else begin
        checkOutput("idleData", config_data, 32'd0);
        if (inWrite) begin
          checkOutput("holdLen", 32'(holdLen), 32'(HOLD));
          inWrite = 1'b0;
        end
      end
      if (prevBusy && !busy) begin
        if (expResults.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedFrameEnd actual=busy_fell expected=no_frame");
        end else begin
          expR = expResults.pop_front();
          checkOutput("frameDone", {31'd0, done}, {31'd0, expR[17]});
          checkOutput("frameError", {31'd0, error}, {31'd0, expR[16]});
          checkOutput("frameWriteCount", {16'd0, write_count}, {16'd0, expR[15:0]});
        end
      end
      prevBusy = busy;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] hdr;
    int n;
    logic [31:0] sum;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstReady", {31'd0, in_ready}, 32'd0);
    checkOutput("rstAddr", config_addr, IDLE);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idleAddr", config_addr, IDLE);
    checkOutput("idleDataReg", config_data, 32'd0);
    checkOutput("idleReady", {31'd0, in_ready}, 32'd1);
    checkOutput("idleBusy", {31'd0, busy}, 32'd0);
    checkOutput("idleDone", {31'd0, done}, 32'd0);
    checkOutput("idleError", {31'd0, error}, 32'd0);
    checkOutput("idleCount", {16'd0, write_count}, 32'd0);

    // Single directed write
    frameAddr[0] = 32'h0006_0010;
    frameData[0] = 32'h0000_0005;
    applyStimulus(1, 32'hC0F7_0014, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("singleCount", {16'd0, write_count}, 32'd1);
    checkOutput("singleDone", {31'd0, done}, 32'd1);
    checkOutput("singleError", {31'd0, error}, 32'd0);

    // Three pairs back to back
    for (int i = 0; i < 3; i++) begin
      frameAddr[i] = 32'h0001_0000 + 32'(i);
      frameData[i] = 32'hA000_0000 + 32'(i * 3);
    end
    sum = 32'hC0F1_0003;
    for (int i = 0; i < 3; i++) sum = sum ^ frameAddr[i] ^ frameData[i];
    applyStimulus(3, sum, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("tripleCount", {16'd0, write_count}, 32'd3);

    // Bad magic then zero-count frame
    sendBadHeader(32'hBEEF_0001);
    applyStimulus(0, 32'hC0F1_0000, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("zeroDone", {31'd0, done}, 32'd1);
    checkOutput("zeroError", {31'd0, error}, 32'd0);

    // Checksum mismatch still writes
    frameAddr[0] = 32'h0022_0004;
    frameData[0] = 32'h1234_5678;
    applyStimulus(1, 32'h0000_0000, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("mismatchDone", {31'd0, done}, 32'd1);
    checkOutput("mismatchError", {31'd0, error}, 32'd1);
    checkOutput("mismatchCount", {16'd0, write_count}, 32'd1);

    // Randomized frames with stalls, corrupt trailers and bad headers
    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(0, 5) == 0) begin
        hdr = $urandom();
        if (hdr[31:16] == 16'hC0F1) hdr[31] = 1'b0;
        sendBadHeader(hdr);
      end
      n = int'($urandom_range(0, 5));
      sum = {16'hC0F1, 16'(n)};
      for (int i = 0; i < n; i++) begin
        frameAddr[i] = $urandom();
        if (frameAddr[i] == IDLE) frameAddr[i] = 32'd0;
        frameData[i] = $urandom();
        sum = sum ^ frameAddr[i] ^ frameData[i];
      end
      if ($urandom_range(0, 3) == 0) sum = sum ^ (32'd1 << $urandom_range(0, 31));
      applyStimulus(n, sum, 1'b1);
    end
    repeat (4) @(negedge clk);

    // Asynchronous reset during the first hold cycle
    frameAddr[0] = 32'h0055_0100;
    frameData[0] = 32'hDEAD_BEEF;
    sendWord(32'hC0F1_0001, 0);
    sendWord(frameAddr[0], 0);
    expWrites.push_back({frameAddr[0], frameData[0]});
    sendWord(frameData[0], 0);
    checkOutput("preResetBusAddr", config_addr, frameAddr[0]);
    reset = 1'b0;
    #1;
    checkOutput("asyncResetAddr", config_addr, IDLE);
    checkOutput("asyncResetData", config_data, 32'd0);
    checkOutput("asyncResetBusy", {31'd0, busy}, 32'd0);
    checkOutput("asyncResetCount", {16'd0, write_count}, 32'd0);
    expWrites.delete();
    expResults.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("postResetReady", {31'd0, in_ready}, 32'd1);
    checkOutput("postResetBusy", {31'd0, busy}, 32'd0);
    checkOutput("postResetCount", {16'd0, write_count}, 32'd0);
    checkOutput("postResetAddr", config_addr, IDLE);

    repeat (4) @(negedge clk);
    checkOutput("pendingWrites", 32'(expWrites.size()), 32'd0);
    checkOutput("pendingResults", 32'(expResults.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
